// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, state
// encodings and the select codes driven to the extender, ALU, register file
// write port and PC mux.
package cu_pkg;

  localparam int OPW = 6;
  localparam int STW = 3;

  // Opcodes (instruction[31:26])
  localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b000010;
  localparam logic [OPW-1:0] OP_OR    = 6'b010000;
  localparam logic [OPW-1:0] OP_AND   = 6'b010001;
  localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPW-1:0] OP_SLT   = 6'b100110;
  localparam logic [OPW-1:0] OP_SLTIU = 6'b100111;
  localparam logic [OPW-1:0] OP_SW    = 6'b110000;
  localparam logic [OPW-1:0] OP_LW    = 6'b110001;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
  localparam logic [OPW-1:0] OP_J     = 6'b111000;
  localparam logic [OPW-1:0] OP_JR    = 6'b111001;
  localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
  localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

  typedef enum logic [STW-1:0] {
    S_IF     = 3'd0,
    S_ID     = 3'd1,
    S_EXE_AL = 3'd2,
    S_EXE_BR = 3'd3,
    S_EXE_LS = 3'd4,
    S_MEM    = 3'd5,
    S_WB_AL  = 3'd6,
    S_WB_LD  = 3'd7
  } state_t;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_LTU = 3'b101;
  localparam logic [2:0] ALU_LT  = 3'b110;

  // Immediate extender modes
  localparam logic [1:0] EXT_SHAMT = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_SIGN  = 2'b10;
  localparam logic [1:0] EXT_CONST = 2'b11;

  // Register file write address select
  localparam logic [1:0] REG_RA = 2'b00;
  localparam logic [1:0] REG_RT = 2'b01;
  localparam logic [1:0] REG_RD = 2'b10;

  // Next-PC select
  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // True for every opcode in the instruction set; anything else runs as a nop.
  function automatic logic is_known(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT,
      OP_SLTIU, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J, OP_JR, OP_JAL,
      OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Static opcode decode: the datapath selects that stay fixed for the whole
// execute/memory/write-back portion of an instruction.
// Ports:
//   opcode    in  6  instruction[31:26]
//   ext_sel   out 2  immediate extender mode
//   alu_op    out 3  ALU operation
//   alu_src_a out 1  1 = extended shamt, 0 = rs
//   alu_src_b out 1  1 = extended immediate, 0 = rt
//   reg_dst   out 2  register file write address select
module cu_decode
  import cu_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output logic [1:0]     ext_sel,
  output logic [2:0]     alu_op,
  output logic           alu_src_a,
  output logic           alu_src_b,
  output logic [1:0]     reg_dst
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned; a missing default here would infer a latch.
  always_comb begin
    ext_sel   = EXT_CONST;
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    reg_dst   = REG_RA;

    case (opcode)
      OP_ADD:   begin alu_op = ALU_ADD; reg_dst = REG_RD; end
      OP_SUB:   begin alu_op = ALU_SUB; reg_dst = REG_RD; end
      OP_OR:    begin alu_op = ALU_OR;  reg_dst = REG_RD; end
      OP_AND:   begin alu_op = ALU_AND; reg_dst = REG_RD; end
      OP_SLT:   begin alu_op = ALU_LT;  reg_dst = REG_RD; end
      OP_SLL: begin
        ext_sel   = EXT_SHAMT;
        alu_op    = ALU_SLL;
        alu_src_a = 1'b1;
        reg_dst   = REG_RD;
      end
      OP_ADDI: begin
        ext_sel = EXT_SIGN; alu_op = ALU_ADD; alu_src_b = 1'b1; reg_dst = REG_RT;
      end
      OP_ORI: begin
        ext_sel = EXT_ZERO; alu_op = ALU_OR; alu_src_b = 1'b1; reg_dst = REG_RT;
      end
      OP_SLTIU: begin
        ext_sel = EXT_ZERO; alu_op = ALU_LTU; alu_src_b = 1'b1; reg_dst = REG_RT;
      end
      OP_LW: begin
        ext_sel = EXT_SIGN; alu_op = ALU_ADD; alu_src_b = 1'b1; reg_dst = REG_RT;
      end
      OP_SW: begin
        ext_sel = EXT_SIGN; alu_op = ALU_ADD; alu_src_b = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ext_sel = EXT_SIGN; alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle control unit. Steps each instruction through IF/ID/EXE/MEM/WB,
// producing the per-cycle write enables and datapath mux selects. A halt
// opcode parks the machine in ID until reset.
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-low reset
//   opcode     in   instruction[31:26] from the instruction register
//   zero       in   ALU result == 0 (meaningful in EXE_BR)
//   PCWre, IRWre, InsMemRW, RegWre, mRD, mWR        enables / strobes
//   ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegDst         datapath selects
//   WrRegDSrc, DBDataSrc, PCSrc                     write-back / PC selects
//   state      out  current state (debug)
module multi_cycle_control
  import cu_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           PCWre,
  output logic           IRWre,
  output logic           InsMemRW,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic [1:0]     ExtSel,
  output logic [1:0]     RegDst,
  output logic           RegWre,
  output logic           WrRegDSrc,
  output logic           DBDataSrc,
  output logic           mRD,
  output logic           mWR,
  output logic [1:0]     PCSrc,
  output logic [STW-1:0] state
);

  state_t     state_q, state_d;
  logic [1:0] dec_ext_sel, dec_reg_dst;
  logic [2:0] dec_alu_op;
  logic       dec_src_a, dec_src_b;
  logic       in_exec;   // EXE, MEM or WB: decode fields are live

  cu_decode u_decode (
    .opcode    (opcode),
    .ext_sel   (dec_ext_sel),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b),
    .reg_dst   (dec_reg_dst)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of its inputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IF;
    else      state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_J, OP_JR, OP_JAL:                  state_d = S_IF;
          OP_HALT:                              state_d = S_ID;
          OP_BEQ, OP_BNE:                       state_d = S_EXE_BR;
          OP_LW, OP_SW:                         state_d = S_EXE_LS;
          OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
          OP_ORI, OP_SLL, OP_SLT, OP_SLTIU:     state_d = S_EXE_AL;
          default:                              state_d = S_IF;
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
      S_WB_AL:  state_d = S_IF;
      S_WB_LD:  state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  assign in_exec = (state_q != S_IF) && (state_q != S_ID);

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = PC_NEXT;
    ExtSel    = in_exec ? dec_ext_sel : 2'b00;
    ALUOp     = in_exec ? dec_alu_op  : 3'b000;
    ALUSrcA   = in_exec & dec_src_a;
    ALUSrcB   = in_exec & dec_src_b;
    RegDst    = in_exec ? dec_reg_dst : REG_RA;

    case (state_q)
      S_IF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
      end
      S_ID: begin
        case (opcode)
          OP_J:  begin PCWre = 1'b1; PCSrc = PC_JUMP; end
          OP_JR: begin PCWre = 1'b1; PCSrc = PC_RS;   end
          OP_JAL: begin
            PCWre  = 1'b1;
            PCSrc  = PC_JUMP;
            RegWre = 1'b1;
            RegDst = REG_RA;   // link register; write data is PC+4
          end
          default: PCWre = !is_known(opcode);   // nop retires in ID
        endcase
      end
      S_EXE_BR: begin
        ALUOp  = ALU_SUB;
        ExtSel = EXT_SIGN;
        PCWre  = 1'b1;
        if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero))
          PCSrc = PC_BRANCH;
      end
      S_MEM: begin
        if (opcode == OP_LW) mRD = 1'b1;
        if (opcode == OP_SW) begin
          mWR   = 1'b1;
          PCWre = 1'b1;
        end
      end
      S_WB_AL, S_WB_LD: begin
        RegWre    = 1'b1;
        PCWre     = 1'b1;
        WrRegDSrc = 1'b1;
        DBDataSrc = (state_q == S_WB_LD);
      end
      default: ;
    endcase

    // Reset suppresses every architectural write, including the IF fetch
    // strobe that the reset state would otherwise drive.
    if (!RST) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mWR    = 1'b0;
      mRD    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control. Each instruction is described
// as a transaction: the sequence of states it visits and the single cycle in
// which each write or strobe fires, derived from the instruction class.
module tb_multi_cycle_control;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] ExtSel, RegDst, PCSrc;
  logic       RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  multi_cycle_control dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
    .RegDst(RegDst), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef enum {K_ALU, K_LW, K_SW, K_BR, K_JMP, K_NOP, K_HALT} kind_t;

  logic [5:0] valid_ops [16] = '{
    6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
    6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001, 6'b110100,
    6'b110101, 6'b111000, 6'b111001, 6'b111010
  };

  function automatic kind_t kind_of(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
      6'b011000, 6'b100110, 6'b100111: return K_ALU;
      6'b110001: return K_LW;
      6'b110000: return K_SW;
      6'b110100, 6'b110101: return K_BR;
      6'b111000, 6'b111001, 6'b111010: return K_JMP;
      6'b111111: return K_HALT;
      default: return K_NOP;
    endcase
  endfunction

  // Expected {ExtSel, ALUOp, ALUSrcA, ALUSrcB} straight from the opcode tables.
  function automatic logic [6:0] fields_of(input logic [5:0] op);
    logic [1:0] ext;
    logic [2:0] aop;
    ext = (op == 6'b011000) ? 2'b00 :
          (op == 6'b010010 || op == 6'b100111) ? 2'b01 :
          (op == 6'b000010 || op == 6'b110001 || op == 6'b110000 ||
           op == 6'b110100 || op == 6'b110101) ? 2'b10 : 2'b11;
    case (op)
      6'b000001, 6'b110100, 6'b110101: aop = 3'b001;
      6'b011000:                       aop = 3'b010;
      6'b010000, 6'b010010:            aop = 3'b011;
      6'b010001:                       aop = 3'b100;
      6'b100111:                       aop = 3'b101;
      6'b100110:                       aop = 3'b110;
      default:                         aop = 3'b000;
    endcase
    return {ext, aop, op == 6'b011000,
            op == 6'b000010 || op == 6'b010010 || op == 6'b100111 ||
            op == 6'b110001 || op == 6'b110000};
  endfunction

  // Register destination for instructions that write the register file.
  function automatic logic [1:0] regdst_of(input logic [5:0] op);
    if (op == 6'b111010) return 2'b00;
    if (op == 6'b000010 || op == 6'b010010 || op == 6'b100111 || op == 6'b110001)
      return 2'b01;
    return 2'b10;
  endfunction

  // Runs one instruction starting in IF (called away from the clock edge).
  task automatic run_instr(input logic [5:0] op, input logic z, input string name);
    kind_t      k;
    int         seq[$];
    int         last;
    logic       writes_reg, taken;
    logic [1:0] target;
    logic [7:0] exp_en, act_en;
    logic [1:0] exp_src;
    k = kind_of(op);
    case (k)
      K_ALU:   seq = '{0, 1, 2, 6};
      K_LW:    seq = '{0, 1, 4, 5, 7};
      K_SW:    seq = '{0, 1, 4, 5};
      K_BR:    seq = '{0, 1, 3};
      default: seq = '{0, 1};
    endcase
    last       = seq.size() - 1;
    writes_reg = (k == K_ALU) || (k == K_LW) || (op == 6'b111010);
    taken      = (op == 6'b110100 && z) || (op == 6'b110101 && !z);
    target     = (op == 6'b111000 || op == 6'b111010) ? 2'b11 :
                 (op == 6'b111001) ? 2'b10 : (k == K_BR && taken) ? 2'b01 : 2'b00;
    opcode = op;
    zero   = z;
    for (int i = 0; i <= last; i++) begin
      n_checks++;
      if (state !== 3'(seq[i]))
        $display("FAIL %s state[%0d]: got %0d expected %0d", name, i, state, seq[i]);
      else n_pass++;

      exp_en = {i == last, i == 0, i == 0, writes_reg && i == last,
                k == K_LW && i == 3, k == K_SW && i == last,
                (k == K_ALU || k == K_LW) && i == last, k == K_LW && i == last};
      act_en = {PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, WrRegDSrc, DBDataSrc};
      n_checks++;
      if (act_en !== exp_en)
        $display("FAIL %s enables[%0d]: got %b expected %b", name, i, act_en, exp_en);
      else n_pass++;

      exp_src = (i == last) ? target : 2'b00;
      n_checks++;
      if (PCSrc !== exp_src)
        $display("FAIL %s PCSrc[%0d]: got %b expected %b", name, i, PCSrc, exp_src);
      else n_pass++;

      if (i >= 2) begin
        n_checks++;
        if ({ExtSel, ALUOp, ALUSrcA, ALUSrcB} !== fields_of(op))
          $display("FAIL %s fields[%0d]: got %b expected %b", name, i,
                   {ExtSel, ALUOp, ALUSrcA, ALUSrcB}, fields_of(op));
        else n_pass++;
      end
      if (writes_reg && i == last) begin
        n_checks++;
        if (RegDst !== regdst_of(op))
          $display("FAIL %s RegDst: got %b expected %b", name, RegDst, regdst_of(op));
        else n_pass++;
      end
      @(posedge CLK);
      @(negedge CLK);
    end
    n_checks++;
    if (state !== 3'd0)
      $display("FAIL %s return to IF: got %0d expected 0", name, state);
    else n_pass++;
  endtask

  task automatic test_reset();
    RST    = 1'b0;
    opcode = 6'b110000;
    zero   = 1'b0;
    #3;
    n_checks++;
    if (state !== 3'd0 || {PCWre, IRWre, RegWre, mWR, mRD} !== 5'b0)
      $display("FAIL reset_hold: got state %0d en %b expected 0 00000",
               state, {PCWre, IRWre, RegWre, mWR, mRD});
    else n_pass++;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (state !== 3'd0 || {PCWre, IRWre, RegWre, mWR, mRD} !== 5'b0)
      $display("FAIL reset_clocked: got state %0d en %b expected 0 00000",
               state, {PCWre, IRWre, RegWre, mWR, mRD});
    else n_pass++;
    RST = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || IRWre !== 1'b1)
      $display("FAIL reset_release: got state %0d IRWre %b expected 0 1", state, IRWre);
    else n_pass++;
  endtask

  task automatic test_addi();
    run_instr(6'b000010, 1'b0, "addi");
  endtask

  task automatic test_lw_sw();
    run_instr(6'b110001, 1'b0, "lw");
    run_instr(6'b110000, 1'b1, "sw");
  endtask

  task automatic test_branch();
    run_instr(6'b110100, 1'b1, "beq_taken");
    run_instr(6'b110100, 1'b0, "beq_not");
    run_instr(6'b110101, 1'b1, "bne_not");
    run_instr(6'b110101, 1'b0, "bne_taken");
  endtask

  task automatic test_jumps();
    run_instr(6'b111010, 1'b0, "jal");
    run_instr(6'b111001, 1'b0, "jr");
    run_instr(6'b111000, 1'b1, "j");
    run_instr(6'b011000, 1'b0, "sll");
    run_instr(6'b000011, 1'b0, "nop");
  endtask

  task automatic test_halt();
    opcode = 6'b111111;
    @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (state !== 3'd1 || PCWre !== 1'b0)
        $display("FAIL halt[%0d]: got state %0d PCWre %b expected 1 0", i, state, PCWre);
      else n_pass++;
      @(posedge CLK);
      @(negedge CLK);
    end
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || {PCWre, IRWre, RegWre, mWR, mRD} !== 5'b0)
      $display("FAIL halt_reset: got state %0d en %b expected 0 00000",
               state, {PCWre, IRWre, RegWre, mWR, mRD});
    else n_pass++;
    @(negedge CLK);
    RST = 1'b1;
    #1;
  endtask

  task automatic test_reset_in_mem();
    opcode = 6'b110000;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    n_checks++;
    if (state !== 3'd5 || mWR !== 1'b1)
      $display("FAIL sw_mem_reach: got state %0d mWR %b expected 5 1", state, mWR);
    else n_pass++;
    #1 RST = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || mWR !== 1'b0 || PCWre !== 1'b0)
      $display("FAIL mem_abort: got state %0d mWR %b PCWre %b expected 0 0 0",
               state, mWR, PCWre);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    run_instr(6'b000010, 1'b0, "restart_addi");
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'b000011;
        for (int t = 0; t < 64; t++) begin
          op = 6'($urandom_range(0, 63));
          if (kind_of(op) == K_NOP) break;
        end
        if (kind_of(op) != K_NOP) op = 6'b000011;
      end else begin
        op = valid_ops[$urandom_range(0, 15)];
      end
      run_instr(op, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_sw();
    test_branch();
    test_jumps();
    test_halt();
    test_reset_in_mem();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Multi-cycle control unit; sits directly upstream of the immediate extender, ALU-source muxes, register file and data memory.
- Sequences every instruction through IF/ID/EXE/MEM/WB states.
- Decodes the 6-bit opcode from the instruction register, including the 2-bit ExtSel that drives the extender.
- Produces all per-cycle write enables and mux selects. Halt freezes the machine in ID.

Parameters:
- OPW, 6, opcode width
- STW, 3, state register width

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- opcode  in  6  instruction[31:26], from the instruction register
- zero  in  1  ALU result == 0, valid in EXE_BR
- PCWre  out  1  PC write enable
- IRWre  out  1  instruction register write enable
- InsMemRW  out  1  instruction memory read
- ALUSrcA  out  1  1 = shamt (extended), 0 = rs
- ALUSrcB  out  1  1 = imm_32, 0 = rt
- ALUOp  out  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 unsigned-less, 110 signed-less
- ExtSel  out  2  00 shamt, 01 zero-extend, 10 sign-extend, 11 zero constant
- RegDst  out  2  00 $31, 01 rt, 10 rd
- RegWre  out  1  register file write enable
- WrRegDSrc  out  1  0 = PC+4, 1 = DB
- DBDataSrc  out  1  0 = ALU, 1 = data memory
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- PCSrc  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target
- state  out  3  current state, for debug

Behaviour:
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sltiu 100111, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111. Any other opcode is a nop: ID returns to IF with PCWre=1.
- States: IF=0, ID=1, EXE_AL=2, EXE_BR=3, EXE_LS=4, MEM=5, WB_AL=6, WB_LD=7.
- Transitions:
  - IF->ID.
  - ID: j/jr/jal->IF; halt->ID (stays); beq/bne->EXE_BR; lw/sw->EXE_LS; ALU ops->EXE_AL.
  - EXE_AL->WB_AL->IF.
  - EXE_BR->IF.
  - EXE_LS->MEM.
  - MEM: sw->IF; lw->WB_LD->IF.
- Outputs are combinational from state and opcode. Any output not listed as asserted is 0.
  - IF: IRWre=1, InsMemRW=1.
  - ID: PCWre=1 for j/jr/jal/nop. PCSrc=11 for j/jal, 10 for jr. jal also asserts RegWre=1, RegDst=00, WrRegDSrc=0.
  - EXE_BR: ALUOp=001, ExtSel=10, PCWre=1. PCSrc=01 iff (beq&zero)|(bne&!zero), else 00.
  - MEM: lw asserts mRD=1; sw asserts mWR=1 and PCWre=1.
  - WB_AL/WB_LD: RegWre=1, PCWre=1, WrRegDSrc=1. RegDst=10 for R-type, 01 for immediate ops and lw. DBDataSrc=1 for WB_LD only.
- Decode fields are held constant across EXE, MEM and WB:
  - ExtSel: 00 sll; 01 ori/sltiu; 10 addi/lw/sw/beq/bne; 11 otherwise.
  - ALUSrcA=1 for sll.
  - ALUSrcB=1 for addi/ori/sltiu/lw/sw.
  - ALUOp: add/addi/lw/sw 000; sub/beq/bne 001; sll 010; or/ori 011; and 100; sltiu 101; slt 110.
- Reset:
  - RST low forces state=IF asynchronously.
  - While RST is low, PCWre/IRWre/RegWre/mWR/mRD are forced to 0.
  - Asserting reset mid-instruction aborts it with no write.
  - The first IF occurs on the first rising edge after RST deasserts.
- Halt: state stays in ID and PCWre stays 0 until reset.
- Latency (cycles): j/jr/jal 2; beq/bne 3; sw 4; ALU ops 4; lw 5.

Decomposition:
- Package cu_pkg: opcode localparams, state encodings, ALUOp/ExtSel/RegDst/PCSrc codes.
- One natural sub-module, cu_decode: purely combinational, opcode -> ExtSel/ALUOp/ALUSrcA/ALUSrcB/RegDst.
- The top level holds the state register, next-state logic and per-state enable gating.

Test Plan:
- Reset release, opcode=addi -> states 0,1,2,6,0. WB_AL asserts RegWre=1, RegDst=01, ExtSel=10, ALUSrcB=1, PCWre=1.
- lw then sw -> lw visits 0,1,4,5,7 with mRD=1 in MEM and DBDataSrc=1 in WB_LD. sw visits 0,1,4,5 with mWR=1 and PCWre=1 in MEM; RegWre stays 0.
- beq with zero=1 -> EXE_BR shows PCSrc=01; with zero=0 -> PCSrc=00. bne shows the inverse. Each takes 3 cycles.
- jal -> ID asserts PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, PCWre=1. jr -> PCSrc=10. sll -> ExtSel=00, ALUSrcA=1, ALUOp=010.
- halt -> state holds 1 for 20 cycles with PCWre=0. Pulsing RST low -> state=0 immediately, with all write enables 0 during reset.
- Reset asserted in MEM of sw -> mWR drops asynchronously; the next instruction restarts at IF.
